adc_sample_front: RTL and testbench

- Capture stage directly downstream of the clock/reset manager; runs on the gated 50 MHz phase-0 clock with its released reset.
- Generates the ADC conversion clock and captures parallel ADC samples.
- Discards a fixed number of settling samples after start, then block-averages (decimates) by 2^DEC_LOG2.
- Delivers rounded averages to the wavelet filter chain over a single-entry valid/ready output register, with sticky overflow reporting.

---
 rtl/adc_pkg.sv | 16 +
 rtl/adc_out_slot.sv | 56 +++++
 rtl/adc_sample_front.sv | 125 ++++++++++++
 tb/tb_adc_sample_front.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
// Shared definitions for the ADC capture front end and the wavelet filter stage.
package adc_pkg;

   // Capture state machine encoding
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } adc_state_e;

   // Default sample width, decimation and settle length shared with the filter chain
   localparam int ADC_DW_DEF       = 10;
   localparam int ADC_DEC_LOG2_DEF = 2;
   localparam int ADC_SETTLE_DEF   = 16;

endpackage

// File: rtl/adc_out_slot.sv
// Single-entry valid/ready output holding register with drop detection
// and a sticky overflow flag.
module adc_out_slot #(
   parameter int DW = 10
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          load,
   input  logic [DW-1:0] load_data,
   input  logic          ready,
   input  logic          ovf_clr,
   output logic [DW-1:0] data,
   output logic          valid,
   output logic          overflow
);

   logic [DW-1:0] data_q, data_d;
   logic          valid_q, valid_d;
   logic          ovf_q, ovf_d;
   logic          drop;

   // Load when the slot is empty or drained this cycle; otherwise the new result is lost
   always_comb begin
      data_d  = data_q;
      valid_d = valid_q;
      ovf_d   = ovf_q;
      drop    = load & valid_q & ~ready;
      if (load && (!valid_q || ready)) begin
         data_d  = load_data;
         valid_d = 1'b1;
      end else if (valid_q && ready) begin
         valid_d = 1'b0;
      end
      // A drop in the same cycle as a clear wins, so no loss goes unreported
      if (drop)         ovf_d = 1'b1;
      else if (ovf_clr) ovf_d = 1'b0;
   end

   // Slot registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         data_q  <= '0;
         valid_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         valid_q <= valid_d;
         ovf_q   <= ovf_d;
      end
   end

   assign data     = data_q;
   assign valid    = valid_q;
   assign overflow = ovf_q;

endmodule

// File: rtl/adc_sample_front.sv
// ADC capture front end: drives the conversion clock at clk/2, drops the
// settling samples after each start, then block-averages 2^DEC_LOG2 captures
// into a rounded result handed to the output slot.
module adc_sample_front
   import adc_pkg::*;
#(
   parameter int DW       = ADC_DW_DEF,
   parameter int DEC_LOG2 = ADC_DEC_LOG2_DEF,
   parameter int SETTLE   = ADC_SETTLE_DEF
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          en,
   input  logic [DW-1:0] adc_data,
   output logic          adc_clk,
   output logic [DW-1:0] samp_data,
   output logic          samp_valid,
   input  logic          samp_ready,
   output logic          overflow,
   input  logic          ovf_clr,
   output logic          busy
);

   localparam int AW = DW + DEC_LOG2;
   localparam int CW = DEC_LOG2 + 1;
   // Half an LSB of the shifted result; zero in pass-through mode
   localparam logic [AW:0]   RND_V       = (AW+1)'((2 ** DEC_LOG2) / 2);
   localparam logic [CW-1:0] DEC_LAST    = CW'((2 ** DEC_LOG2) - 1);
   localparam logic [7:0]    SETTLE_LAST = 8'(SETTLE - 1);

   adc_state_e    state_q, state_d;
   logic          ph_q, ph_d;
   logic [7:0]    settle_cnt_q, settle_cnt_d;
   logic [CW-1:0] dec_cnt_q, dec_cnt_d;
   logic [AW-1:0] acc_q, acc_d;
   logic [AW:0]   sum;
   logic          res_vld;
   logic [DW-1:0] res_data;

   // Next-state: phase toggle, settle/decimation counting and accumulation
   always_comb begin
      state_d      = state_q;
      ph_d         = ph_q;
      settle_cnt_d = settle_cnt_q;
      dec_cnt_d    = dec_cnt_q;
      acc_d        = acc_q;
      res_vld      = 1'b0;
      sum          = {1'b0, acc_q} + (AW+1)'(adc_data) + RND_V;
      res_data     = DW'(sum >> DEC_LOG2);
      case (state_q)
         ST_IDLE: begin
            ph_d = 1'b0;
            if (en) begin
               state_d      = ST_SETTLE;
               settle_cnt_d = '0;
               dec_cnt_d    = '0;
               acc_d        = '0;
            end
         end
         ST_SETTLE, ST_RUN: begin
            if (!en) begin
               // Partial group is abandoned; a restart always re-settles
               state_d      = ST_IDLE;
               ph_d         = 1'b0;
               settle_cnt_d = '0;
               dec_cnt_d    = '0;
               acc_d        = '0;
            end else begin
               ph_d = ~ph_q;
               // ph high before the edge marks the ADC capture edge
               if (ph_q) begin
                  if (state_q == ST_SETTLE) begin
                     settle_cnt_d = settle_cnt_q + 8'd1;
                     if (settle_cnt_q == SETTLE_LAST) state_d = ST_RUN;
                  end else if (dec_cnt_q == DEC_LAST) begin
                     res_vld   = 1'b1;
                     acc_d     = '0;
                     dec_cnt_d = '0;
                  end else begin
                     acc_d     = acc_q + AW'(adc_data);
                     dec_cnt_d = dec_cnt_q + CW'(1);
                  end
               end
            end
         end
         default: begin
            state_d = ST_IDLE;
            ph_d    = 1'b0;
         end
      endcase
   end

   // Control and datapath registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q      <= ST_IDLE;
         ph_q         <= 1'b0;
         settle_cnt_q <= '0;
         dec_cnt_q    <= '0;
         acc_q        <= '0;
      end else begin
         state_q      <= state_d;
         ph_q         <= ph_d;
         settle_cnt_q <= settle_cnt_d;
         dec_cnt_q    <= dec_cnt_d;
         acc_q        <= acc_d;
      end
   end

   assign adc_clk = ph_q;
   assign busy    = (state_q != ST_IDLE);

   adc_out_slot #(.DW(DW)) u_slot (
      .clk       (clk),
      .rst_n     (reset),
      .load      (res_vld),
      .load_data (res_data),
      .ready     (samp_ready),
      .ovf_clr   (ovf_clr),
      .data      (samp_data),
      .valid     (samp_valid),
      .overflow  (overflow)
   );

endmodule

// File: tb/tb_adc_sample_front.sv
// Bench for adc_sample_front: directed scenarios plus randomized traffic,
// compared every cycle against a timing/averaging reference model.
module tb_adc_sample_front;

   localparam int DW       = 10;
   localparam int DEC_LOG2 = 2;
   localparam int SETTLE   = 16;
   localparam int NDEC     = 1 << DEC_LOG2;
   localparam int FIRST    = 2 * (SETTLE + NDEC);

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          en = 1'b0;
   logic [DW-1:0] adc_data = '0;
   logic          adc_clk;
   logic [DW-1:0] samp_data;
   logic          samp_valid;
   logic          samp_ready = 1'b0;
   logic          overflow;
   logic          ovf_clr = 1'b0;
   logic          busy;

   int n_tests = 0;
   int n_fail  = 0;

   // Reference model state: edges since start, current group, output slot
   bit m_act;
   int m_k, m_sum, m_cnt;
   bit m_valid, m_ovf;
   int m_data;

   adc_sample_front dut (
      .clk        (clk),
      .reset      (reset),
      .en         (en),
      .adc_data   (adc_data),
      .adc_clk    (adc_clk),
      .samp_data  (samp_data),
      .samp_valid (samp_valid),
      .samp_ready (samp_ready),
      .overflow   (overflow),
      .ovf_clr    (ovf_clr),
      .busy       (busy)
   );

   always #10 clk = ~clk;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_act = 0; m_k = 0; m_sum = 0; m_cnt = 0;
      m_valid = 0; m_ovf = 0; m_data = 0;
   endtask

   // One clock edge of the reference behaviour, using the inputs present at the edge
   task automatic model_edge();
      bit res_v;
      int res;
      bit drop;
      res_v = 0; res = 0;
      if (!m_act) begin
         if (en) begin m_act = 1; m_k = 0; m_sum = 0; m_cnt = 0; end
      end else if (!en) begin
         m_act = 0;
      end else begin
         m_k++;
         if (m_k % 2 == 0 && m_k / 2 > SETTLE) begin
            m_sum += int'(adc_data);
            m_cnt++;
            if (m_cnt == NDEC) begin
               res_v = 1;
               res   = (m_sum + NDEC / 2) / NDEC;
               m_sum = 0; m_cnt = 0;
            end
         end
      end
      drop = res_v && m_valid && !samp_ready;
      if (res_v && (!m_valid || samp_ready)) begin
         m_valid = 1; m_data = res;
      end else if (m_valid && samp_ready) begin
         m_valid = 0;
      end
      if (drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
   endtask

   task automatic chk_all();
      chk("adc_clk", int'(adc_clk), (m_act && (m_k % 2 == 1)) ? 1 : 0);
      chk("busy", int'(busy), int'(m_act));
      chk("samp_valid", int'(samp_valid), int'(m_valid));
      chk("samp_data", int'(samp_data), m_data);
      chk("overflow", int'(overflow), int'(m_ovf));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      chk_all();
   endtask

   // Go idle with an empty slot, then count edges from the start to the first result
   task automatic first_valid(input string tag);
      int e;
      bit found;
      en = 0; samp_ready = 1; ovf_clr = 0;
      step(); step();
      en = 1;
      found = 0;
      for (e = 0; e < 100; e++) begin
         step();
         if (samp_valid) begin found = 1; break; end
      end
      chk(tag, found ? e : -1, FIRST);
   endtask

   // Fresh start, then the four RUN captures of the first group use v[]
   task automatic feed4(input string tag, input int v0, input int v1, input int v2,
                        input int v3, input int exp);
      int v[4];
      v[0] = v0; v[1] = v1; v[2] = v2; v[3] = v3;
      en = 0; samp_ready = 1; ovf_clr = 0;
      step(); step();
      en = 1;
      for (int e = 0; e <= FIRST; e++) begin
         if (e >= FIRST - 2 * NDEC + 2 && e % 2 == 0)
            adc_data = DW'(v[(e - (FIRST - 2 * NDEC + 2)) / 2]);
         else
            adc_data = DW'($urandom);
         step();
      end
      chk({tag, "_valid"}, int'(samp_valid), 1);
      chk(tag, int'(samp_data), exp);
   endtask

   initial begin
      int guard;
      model_reset();

      // Reset held: outputs quiet whatever the inputs do
      for (int i = 0; i < 5; i++) begin
         en = 1'($urandom); adc_data = DW'($urandom);
         samp_ready = 1'($urandom); ovf_clr = 1'($urandom);
         @(negedge clk);
         chk("rst_valid", int'(samp_valid), 0);
         chk("rst_data", int'(samp_data), 0);
         chk("rst_ovf", int'(overflow), 0);
         chk("rst_busy", int'(busy), 0);
         chk("rst_adc_clk", int'(adc_clk), 0);
      end
      en = 0; samp_ready = 0; ovf_clr = 0;
      reset = 1;
      for (int i = 0; i < 20; i++) step();

      // Constant input, first result timing and cadence
      adc_data = 10'd100;
      first_valid("first_valid_edge");
      chk("const_data", int'(samp_data), 100);
      for (int i = 0; i < 30; i++) step();

      // Rounding cases
      feed4("round_1222", 1, 2, 2, 2, 2);
      feed4("round_max", 1023, 1023, 1023, 1023, 1023);
      feed4("round_0002", 0, 0, 0, 2, 1);

      // Backpressure: hold across two results, then clear on a quiet cycle
      samp_ready = 0;
      for (int i = 0; i < 18; i++) step();
      chk("bp_ovf_set", int'(overflow), 1);
      guard = 0;
      while (m_k % (2 * NDEC) == 2 * NDEC - 1 && guard < 4) begin step(); guard++; end
      ovf_clr = 1; step(); ovf_clr = 0;
      chk("bp_ovf_clr", int'(overflow), 0);
      samp_ready = 1;
      guard = 0;
      while (!(m_act && (m_k + 1) % (2 * NDEC) == 0) && guard < 20) begin step(); guard++; end
      step();
      chk("bp_swap_ovf", int'(overflow), 0);
      chk("bp_swap_valid", int'(samp_valid), 1);

      // Stop after two RUN captures, then restart from scratch
      en = 0; step(); step();
      en = 1;
      for (int e = 0; e <= FIRST - 2 * NDEC + 4; e++) begin
         adc_data = DW'($urandom); step();
      end
      en = 0; step();
      chk("stop_adc_clk", int'(adc_clk), 0);
      chk("stop_busy", int'(busy), 0);
      for (int i = 0; i < 6; i++) step();
      first_valid("restart_valid_edge");

      // Async reset mid-RUN with a pending sample
      samp_ready = 0;
      for (int i = 0; i < 12; i++) step();
      chk("pre_rst_valid", int'(samp_valid), 1);
      #5 reset = 0;
      #1;
      chk("arst_valid", int'(samp_valid), 0);
      chk("arst_ovf", int'(overflow), 0);
      chk("arst_busy", int'(busy), 0);
      chk("arst_adc_clk", int'(adc_clk), 0);
      model_reset();
      en = 0;
      @(negedge clk);
      reset = 1;
      step();

      // Randomized traffic against the model
      en = 1;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 199) == 0) en = ~en;
         adc_data   = DW'($urandom);
         samp_ready = ($urandom_range(0, 3) != 0);
         ovf_clr    = ($urandom_range(0, 15) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
